selftrigger_channel_sequencer: RTL and testbench

Per-channel controller for the self-trigger filter chain (baseline LPF, HPF, moving integrator, cross-correlation trigger, CFD). It accepts configuration through a valid/ready port and applies it atomically. It flushes the filter with a timed reset, masks triggers while the filters settle, and then qualifies raw CFD triggers with a programmable hold-off. It keeps saturating counts of accepted and vetoed triggers for readout.

---
 rtl/selftrigger_channel_sequencer.sv | 150 +++++++++++++++
 tb/tb_selftrigger_channel_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/selftrigger_channel_sequencer.sv
// Per-channel sequencer for the self-trigger filter chain: atomic config latch,
// timed flush/settle, hold-off trigger qualification and saturating counters.
module selftrigger_channel_sequencer #(
  parameter int unsigned FLUSH_CYCLES      = 4,
  parameter int unsigned SETTLE_CYCLES     = 1024,
  parameter logic [41:0] DEFAULT_THRESHOLD = 42'd256,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_enable,
  input  logic [41:0]      cfg_threshold,
  input  logic [1:0]       cfg_output_selector,
  input  logic [15:0]      cfg_holdoff,
  output logic             filt_reset,
  output logic             filt_enable,
  output logic [41:0]      filt_threshold_xc,
  output logic [1:0]       filt_output_selector,
  input  logic             filt_trigger,
  output logic             trigger_out,
  input  logic             count_clear,
  output logic [CNT_W-1:0] trig_count,
  output logic [CNT_W-1:0] veto_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_SETTLE  = 3'd2,
    S_ARMED   = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  // One down-counter serves flush, settle and hold-off; size it for the longest.
  localparam int TMR_W = ($clog2(SETTLE_CYCLES + 1) > 16) ? $clog2(SETTLE_CYCLES + 1) : 16;
  localparam logic [TMR_W-1:0] FLUSH_LD  = TMR_W'(FLUSH_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
  logic [41:0]        r_thr;
  logic [1:0]         r_sel;
  logic [15:0]        r_hold;
  logic               r_trig_d;
  logic               r_filt_reset, r_filt_enable, r_trig_out;
  logic [CNT_W-1:0]   r_trig_cnt, r_veto_cnt;
  logic               w_acc, w_edge, w_fire, w_veto;
  logic               w_filt_reset_nxt, w_filt_enable_nxt;

  assign w_edge = filt_trigger & ~r_trig_d;
  assign w_acc  = cfg_valid & cfg_ready;

  // State register, timer, config latch and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_tmr         <= '0;
      r_thr         <= DEFAULT_THRESHOLD;
      r_sel         <= 2'd0;
      r_hold        <= 16'd0;
      r_trig_d      <= 1'b0;
      r_filt_reset  <= 1'b1;
      r_filt_enable <= 1'b0;
      r_trig_out    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tmr         <= w_tmr_nxt;
      r_trig_d      <= filt_trigger;
      r_filt_reset  <= w_filt_reset_nxt;
      r_filt_enable <= w_filt_enable_nxt;
      r_trig_out    <= w_fire;
      if (w_acc) begin
        r_thr  <= cfg_threshold;
        r_sel  <= cfg_output_selector;
        r_hold <= cfg_holdoff;
      end
    end
  end

  // Next state; an accepted config pre-empts any trigger activity this cycle
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_fire      = 1'b0;
    w_veto      = 1'b0;
    if (w_acc) begin
      w_state_nxt = cfg_enable ? S_FLUSH : S_IDLE;
      w_tmr_nxt   = FLUSH_LD;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_FLUSH:
          if (r_tmr == '0) begin
            w_state_nxt = S_SETTLE;
            w_tmr_nxt   = SETTLE_LD;
          end else w_tmr_nxt = r_tmr - TMR_W'(1);
        S_SETTLE:
          if (r_tmr == '0) w_state_nxt = S_ARMED;
          else             w_tmr_nxt   = r_tmr - TMR_W'(1);
        S_ARMED:
          if (w_edge) begin
            w_fire = 1'b1;
            if (r_hold != 16'd0) begin
              w_state_nxt = S_HOLDOFF;
              w_tmr_nxt   = TMR_W'(r_hold) - TMR_W'(1);
            end
          end
        S_HOLDOFF: begin
          w_veto = w_edge;
          if (r_tmr == '0) w_state_nxt = S_ARMED;
          else             w_tmr_nxt   = r_tmr - TMR_W'(1);
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    cfg_ready         = (r_state == S_IDLE) || (r_state == S_ARMED) || (r_state == S_HOLDOFF);
    w_filt_reset_nxt  = (w_state_nxt == S_IDLE) || (w_state_nxt == S_FLUSH);
    w_filt_enable_nxt = ~w_filt_reset_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trig_cnt <= '0;
      r_veto_cnt <= '0;
    end else if (count_clear) begin
      r_trig_cnt <= '0;
      r_veto_cnt <= '0;
    end else begin
      if (w_fire && r_trig_cnt != '1) r_trig_cnt <= r_trig_cnt + CNT_W'(1);
      if (w_veto && r_veto_cnt != '1) r_veto_cnt <= r_veto_cnt + CNT_W'(1);
    end
  end

  assign filt_reset           = r_filt_reset;
  assign filt_enable          = r_filt_enable;
  assign filt_threshold_xc    = r_thr;
  assign filt_output_selector = r_sel;
  assign trigger_out          = r_trig_out;
  assign trig_count           = r_trig_cnt;
  assign veto_count           = r_veto_cnt;
  assign state                = r_state;

endmodule

// File: tb/tb_selftrigger_channel_sequencer.sv
// Directed self-checking bench for selftrigger_channel_sequencer (CNT_W=4 to reach saturation).
module tb_selftrigger_channel_sequencer;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_valid = 1'b0, cfg_ready, cfg_enable = 1'b0;
  logic [41:0]      cfg_threshold = '0;
  logic [1:0]       cfg_output_selector = '0;
  logic [15:0]      cfg_holdoff = '0;
  logic             filt_reset, filt_enable;
  logic [41:0]      filt_threshold_xc;
  logic [1:0]       filt_output_selector;
  logic             filt_trigger = 1'b0, trigger_out, count_clear = 1'b0;
  logic [CNT_W-1:0] trig_count, veto_count;
  logic [2:0]       state;

  int n_chk = 0, n_fail = 0;

  selftrigger_channel_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_enable(cfg_enable),
    .cfg_threshold(cfg_threshold), .cfg_output_selector(cfg_output_selector),
    .cfg_holdoff(cfg_holdoff),
    .filt_reset(filt_reset), .filt_enable(filt_enable),
    .filt_threshold_xc(filt_threshold_xc), .filt_output_selector(filt_output_selector),
    .filt_trigger(filt_trigger), .trigger_out(trigger_out),
    .count_clear(count_clear), .trig_count(trig_count), .veto_count(veto_count),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Accept a config, then run through 4 flush + 1024 settle cycles to ARMED.
  task automatic cfg_to_armed(input logic [41:0] thr, input logic [1:0] sel, input logic [15:0] hold);
    cfg_valid = 1'b1; cfg_enable = 1'b1;
    cfg_threshold = thr; cfg_output_selector = sel; cfg_holdoff = hold;
    tick();
    cfg_valid = 1'b0;
    repeat (4 + 1024) tick();
    chk("armed_after_cfg", 64'(state), 64'd3);
  endtask

  initial begin
    bit ok;
    // Reset state
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_state",  64'(state), 64'd0);
    chk("rst_frst",   64'(filt_reset), 64'd1);
    chk("rst_fen",    64'(filt_enable), 64'd0);
    chk("rst_thr",    64'(filt_threshold_xc), 64'd256);
    chk("rst_sel",    64'(filt_output_selector), 64'd0);
    chk("rst_tout",   64'(trigger_out), 64'd0);
    chk("rst_tcnt",   64'(trig_count), 64'd0);
    chk("rst_vcnt",   64'(veto_count), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", 64'(cfg_ready), 64'd1);

    // Config accept: FLUSH for 4 cycles
    cfg_valid = 1'b1; cfg_enable = 1'b1;
    cfg_threshold = 42'd1000; cfg_output_selector = 2'd2; cfg_holdoff = 16'd10;
    tick();
    cfg_valid = 1'b0;
    chk("cfg_thr", 64'(filt_threshold_xc), 64'd1000);
    chk("cfg_sel", 64'(filt_output_selector), 64'd2);
    chk("flush_ready", 64'(cfg_ready), 64'd0);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (state != 3'd1 || filt_reset != 1'b1 || filt_enable != 1'b0) ok = 1'b0;
      tick();
    end
    chk("flush_4cyc", 64'(ok), 64'd1);

    // SETTLE 1024 cycles; trigger rises mid-settle and stays high
    ok = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      if (state != 3'd2 || filt_reset != 1'b0 || filt_enable != 1'b1 || trigger_out) ok = 1'b0;
      if (i == 500) filt_trigger = 1'b1;
      tick();
    end
    chk("settle_1024cyc", 64'(ok), 64'd1);
    chk("armed", 64'(state), 64'd3);
    tick(); tick();
    chk("held_level_no_trig", 64'(trigger_out), 64'd0);
    chk("held_level_no_cnt",  64'(trig_count), 64'd0);

    // Drop and re-raise: edge at n, hold-off 10, veto edge at n+5
    filt_trigger = 1'b0; tick();
    filt_trigger = 1'b1; tick();
    chk("trig_n1", 64'(trigger_out), 64'd1);
    chk("hold_n1", 64'(state), 64'd4);
    chk("tcnt_1",  64'(trig_count), 64'd1);
    ok = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (state != 3'd4 || (c > 1 && trigger_out)) ok = 1'b0;
      filt_trigger = (c == 5);
      tick();
    end
    chk("holdoff_10cyc", 64'(ok), 64'd1);
    chk("armed_n11", 64'(state), 64'd3);
    chk("tcnt_still1", 64'(trig_count), 64'd1);
    chk("vcnt_1", 64'(veto_count), 64'd1);

    // Accept with enable=0 in HOLDOFF while an edge arrives
    filt_trigger = 1'b1; tick();
    filt_trigger = 1'b0; tick();
    chk("hold_again", 64'(state), 64'd4);
    cfg_valid = 1'b1; cfg_enable = 1'b0;
    cfg_threshold = 42'd77; cfg_output_selector = 2'd1; cfg_holdoff = 16'd0;
    filt_trigger = 1'b1;
    tick();
    cfg_valid = 1'b0; filt_trigger = 1'b0;
    chk("acc_idle",  64'(state), 64'd0);
    chk("acc_frst",  64'(filt_reset), 64'd1);
    chk("acc_tout",  64'(trigger_out), 64'd0);
    chk("acc_tcnt",  64'(trig_count), 64'd2);
    chk("acc_vcnt",  64'(veto_count), 64'd1);
    chk("acc_thr",   64'(filt_threshold_xc), 64'd77);

    // Holdoff 0: edges two cycles apart both fire
    cfg_to_armed(42'd500, 2'd3, 16'd0);
    filt_trigger = 1'b1; tick();
    chk("h0_trig_a", 64'(trigger_out), 64'd1);
    chk("h0_state",  64'(state), 64'd3);
    filt_trigger = 1'b0; tick();
    chk("h0_gap",    64'(trigger_out), 64'd0);
    filt_trigger = 1'b1; tick();
    chk("h0_trig_b", 64'(trigger_out), 64'd1);
    filt_trigger = 1'b0; tick();
    chk("h0_tcnt",   64'(trig_count), 64'd4);
    chk("h0_vcnt",   64'(veto_count), 64'd1);

    // Saturation: 16 more triggers from 4 must stop at 15
    for (int i = 0; i < 16; i++) begin
      filt_trigger = 1'b1; tick();
      filt_trigger = 1'b0; tick();
    end
    chk("sat_tcnt", 64'(trig_count), 64'd15);

    // Clear wins over a same-cycle increment
    count_clear = 1'b1; filt_trigger = 1'b1; tick();
    count_clear = 1'b0; filt_trigger = 1'b0;
    chk("clr_tout", 64'(trigger_out), 64'd1);
    chk("clr_tcnt", 64'(trig_count), 64'd0);
    chk("clr_vcnt", 64'(veto_count), 64'd0);
    tick();

    // Async reset mid-HOLDOFF takes effect before the next clock edge
    cfg_to_armed(42'd900, 2'd1, 16'd5);
    filt_trigger = 1'b1; tick();
    filt_trigger = 1'b0;
    chk("pre_rst_hold", 64'(state), 64'd4);
    chk("pre_rst_thr",  64'(filt_threshold_xc), 64'd900);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_thr",   64'(filt_threshold_xc), 64'd256);
    chk("arst_sel",   64'(filt_output_selector), 64'd0);
    chk("arst_frst",  64'(filt_reset), 64'd1);
    chk("arst_tcnt",  64'(trig_count), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
